// File: rtl/pie_frame_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pie_frame_encoder
// Purpose  : Encodes one reader-to-tag command frame as a PIE waveform:
//            delimiter, data-0, RTCAL, optional TRCAL, then N data symbols.
//            Symbol timings are run-time inputs latched at frame start.
// Revision : 1.0 - initial release
// ============================================================================
module pie_frame_encoder #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             preamble_sel,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [CNT_W-1:0] cfg_pw,
  input  logic [CNT_W-1:0] cfg_zero,
  input  logic [CNT_W-1:0] cfg_one,
  input  logic [CNT_W-1:0] cfg_rtcal,
  input  logic [CNT_W-1:0] cfg_trcal,
  input  logic [CNT_W-1:0] cfg_delim,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_rdy,
  output logic             out_pie,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELIM = 3'd1,
    S_SYNC0 = 3'd2,
    S_RTCAL = 3'd3,
    S_TRCAL = 3'd4,
    S_DATA0 = 3'd5,
    S_DATA1 = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [LEN_W-1:0] bits_left, bits_left_nxt;
  logic             capture;

  // Frame-constant copies of the configuration, taken when the frame starts
  logic [CNT_W-1:0] pw_q, zero_q, one_q, rtcal_q, trcal_q, delim_q;
  logic             pre_q;

  logic [CNT_W-1:0] period_raw, period;
  logic             sym_end;
  logic             data_slot;
  logic             pulse_high;

  // Period of the symbol currently being emitted (zero is promoted to one)
  always_comb begin
    period_raw = C_CNT_ONE;
    case (state)
      S_DELIM: period_raw = delim_q;
      S_SYNC0: period_raw = zero_q;
      S_RTCAL: period_raw = rtcal_q;
      S_TRCAL: period_raw = trcal_q;
      S_DATA0: period_raw = zero_q;
      S_DATA1: period_raw = one_q;
      default: period_raw = C_CNT_ONE;
    endcase
    period = (period_raw == '0) ? C_CNT_ONE : period_raw;
  end

  // Symbol timing, bit-intake window and frame status flags
  always_comb begin
    sym_end    = (state != S_IDLE) && (count == period - C_CNT_ONE);
    // A data bit is needed after the last calibration symbol or any data symbol
    data_slot  = ((state == S_RTCAL) && !pre_q) || (state == S_TRCAL) ||
                 (state == S_DATA0) || (state == S_DATA1);
    // Low pulse occupies the final pw cycles; pw >= period gives an all-low symbol
    pulse_high = (pw_q < period) && (count < period - pw_q);
    in_rdy     = sym_end && data_slot && (bits_left != '0);
    done       = sym_end && data_slot && (bits_left == '0);
    underrun   = in_rdy && !in_valid;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:  out_pie = 1'b1;
      S_DELIM: out_pie = 1'b0;
      default: out_pie = pulse_high;
    endcase
  end

  // Next-state, symbol counter and bit-count logic
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    bits_left_nxt = bits_left;
    capture       = 1'b0;
    if (state == S_IDLE) begin
      count_nxt = '0;
      if (start) begin
        state_nxt     = S_DELIM;
        bits_left_nxt = frame_len;
        capture       = 1'b1;
      end
    end else if (!sym_end) begin
      count_nxt = count + C_CNT_ONE;
    end else begin
      count_nxt = '0;
      if (state == S_DELIM) begin
        state_nxt = S_SYNC0;
      end else if (state == S_SYNC0) begin
        state_nxt = S_RTCAL;
      end else if ((state == S_RTCAL) && pre_q) begin
        state_nxt = S_TRCAL;
      end else if (bits_left == '0) begin
        // Normal completion
        state_nxt = S_IDLE;
      end else if (in_valid) begin
        state_nxt     = in_bit ? S_DATA1 : S_DATA0;
        bits_left_nxt = bits_left - C_LEN_ONE;
      end else begin
        // Bit source failed to deliver: abort the frame
        state_nxt = S_IDLE;
      end
    end
  end

  // State, counter and latched frame configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      bits_left <= '0;
      pw_q      <= '0;
      zero_q    <= '0;
      one_q     <= '0;
      rtcal_q   <= '0;
      trcal_q   <= '0;
      delim_q   <= '0;
      pre_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      bits_left <= bits_left_nxt;
      if (capture) begin
        pw_q    <= cfg_pw;
        zero_q  <= cfg_zero;
        one_q   <= cfg_one;
        rtcal_q <= cfg_rtcal;
        trcal_q <= cfg_trcal;
        delim_q <= cfg_delim;
        pre_q   <= preamble_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pie_frame_encoder.md
Name: pie_frame_encoder

Overview:
- Parametrised successor of the fixed-timing PIE encoder in the reader TX path.
- Encodes one complete reader→tag command frame: delimiter, data-0, RTCAL, optional TRCAL, then N data bits as pulse-interval (PIE) symbols.
- All symbol timings are run-time configuration inputs, captured at frame start, so Tari and BLF can change between commands without resynthesis.
- Adds a start/busy/done frame handshake, an explicit bit count, valid/ready bit intake and underrun abort.
- Sits between the command builder (bit source) and the modulator (out_pie drives carrier on/off).

Parameters:
- CNT_W, 16, width of the symbol counter and of every timing config port.
- LEN_W, 8, width of frame_len (maximum 2^LEN_W-1 data bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- preamble_sel  in  1  1=preamble (with TRCAL), 0=frame-sync (no TRCAL); captured with start.
- frame_len  in  LEN_W  number of data bits in the frame; captured with start.
- cfg_pw  in  CNT_W  low-pulse width in cycles.
- cfg_zero  in  CNT_W  data-0 period (Tari) in cycles.
- cfg_one  in  CNT_W  data-1 period in cycles.
- cfg_rtcal  in  CNT_W  RTCAL period in cycles.
- cfg_trcal  in  CNT_W  TRCAL period in cycles.
- cfg_delim  in  CNT_W  delimiter length in cycles.
- in_bit  in  1  next data bit.
- in_valid  in  1  in_bit is valid.
- in_rdy  out  1  encoder accepts in_bit this cycle.
- out_pie  out  1  PIE waveform; 1=carrier on.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes normally.
- underrun  out  1  one-cycle pulse when a frame is aborted on underrun.

Behaviour:
- Clocking and reset: all state updates on posedge clk. With rst=1 at an edge: state=IDLE, count=0, latched config=0, bits_left=0, out_pie=1, busy=0, in_rdy=0, done=0, underrun=0. Reset mid-frame truncates the frame immediately; out_pie is 1 from the next cycle.
- States:
  - IDLE: out_pie=1.
  - DELIM: out_pie=0 for the whole period.
  - SYNC0, RTCAL, TRCAL, DATA0, DATA1: for a symbol of period P, out_pie=1 while count < P-cfg_pw and 0 for the last cfg_pw cycles.
- count runs 0..P-1 and is cleared on the last cycle of each symbol (count==P-1, the "symbol end").
- Frame start: start=1 in IDLE at edge N:
  - latch all cfg_*, preamble_sel and frame_len;
  - state=DELIM and count=0 at N+1, so out_pie=0 starting N+1;
  - busy=1 from N+1 until return to IDLE.
  - start while busy is ignored.
- Sequence: DELIM → SYNC0 → RTCAL → (TRCAL if preamble_sel) → data symbols.
- Bit intake:
  - in_rdy=1 only on the symbol-end cycle of RTCAL/TRCAL (whichever is last) or of a data symbol, and only when bits_left>0.
  - On in_rdy & in_valid the bit is consumed, bits_left decrements, and the next state is DATA1 if in_bit=1 else DATA0.
  - in_rdy is combinational from state/count/bits_left and never depends on in_valid.
- Completion: symbol end of the final symbol with bits_left=0 → IDLE, done=1 for that one cycle, out_pie=1 next cycle.
- frame_len=0: preamble/frame-sync only, then done.
- Underrun: in_rdy=1 & in_valid=0 → abort: IDLE next cycle, underrun=1 for that one cycle, done stays 0.
- Config changes while busy have no effect on the current frame.
- Degenerate configs:
  - cfg_pw ≥ P gives an all-low symbol.
  - Any period of 0 is treated as 1.
  - No further checking.

Test Plan:
- Defaults pw=200, zero=500, one=875, rtcal=1375, trcal=4000, delim=312; start with preamble_sel=1, frame_len=0 → out_pie low 312 cycles; then 300 high/200 low, 1175/200, 3800/200; done pulse at total cycle 6187; busy high exactly 6187 cycles.
- Same config, preamble_sel=0, frame_len=3, bits 1,0,1 always valid → no TRCAL; in_rdy pulses at the end of RTCAL and of the first two data symbols; data highs 675/300/675; done after 312+500+1375+875+500+875 cycles.
- Bit source withholds in_valid at the second in_rdy → underrun pulse, done=0, out_pie=1 and busy=0 the next cycle, only 1 data symbol emitted.
- rst asserted mid-TRCAL → next cycle out_pie=1, busy=0, in_rdy=0; a new start then begins with a full delimiter.
- Change cfg_zero from 500 to 250 mid-frame → current frame unchanged; the next frame uses 50-high/200-low data-0 symbols; start pulsed while busy produces no second frame.
